// File: rtl/control_unit_pkg.sv
// ---------------------------------------------------------------------------
// cpuConfig: shared types and constants for the picoMIPS control unit.
//   A_SIZE / O_SIZE / FLAG_W : ALU function, opcode and flag vector widths
//   FLAG_*                   : bit positions inside the {V,N,C,Z} flag vector
//   aluFunc_t                : ALU operation select
//   opCode_t                 : instruction opcodes
//   ctrlState_t              : control FSM states
// ---------------------------------------------------------------------------
package cpuConfig;

    localparam int A_SIZE = 3;
    localparam int O_SIZE = 6;
    localparam int FLAG_W = 4;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [A_SIZE-1:0] {
        ALU_A   = 3'd0,
        ALU_B   = 3'd1,
        ALU_ADD = 3'd2,
        ALU_MUL = 3'd3
    } aluFunc_t;

    typedef enum logic [O_SIZE-1:0] {
        NOP   = 6'd0,
        ADD   = 6'd1,
        ADDI  = 6'd2,
        MUL   = 6'd3,
        LDI   = 6'd4,
        LDS   = 6'd5,
        WAIT0 = 6'd6,
        WAIT1 = 6'd7,
        WAITE = 6'd8,
        BEQ   = 6'd9,
        BNE   = 6'd10
    } opCode_t;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } ctrlState_t;

endpackage

// File: rtl/control_unit_if.sv
// ---------------------------------------------------------------------------
// control_unit_if: instruction/flag inputs and datapath/PC controls of the
// control unit.
//   master : the ROM/datapath side (drives opCode, aluFlags)
//   slave  : the control unit (drives the decoded controls)
// ---------------------------------------------------------------------------
interface control_unit_if;
    import cpuConfig::*;

    logic [O_SIZE-1:0] opCode;
    logic [FLAG_W-1:0] aluFlags;
    aluFunc_t          aluFunc;
    logic              aluImmediate;
    logic              immSwitches;
    logic              pcInc;
    logic              pcLoad;
    logic              writeReg;
    logic              stall;

    modport master (
        output opCode, aluFlags,
        input  aluFunc, aluImmediate, immSwitches, pcInc, pcLoad, writeReg, stall
    );

    modport slave (
        input  opCode, aluFlags,
        output aluFunc, aluImmediate, immSwitches, pcInc, pcLoad, writeReg, stall
    );

endinterface

// File: rtl/control_unit_switch_sync.sv
// ---------------------------------------------------------------------------
// switch_sync: multi-flop synchroniser plus rising-edge detector for an
// asynchronous board switch.
//   clk, reset : system clock, synchronous active-high reset
//   async_in   : raw switch input
//   level      : synchronised switch level (SYNC_STAGES flops deep)
//   rise       : one-cycle pulse on the cycle level goes 0 -> 1
// ---------------------------------------------------------------------------
module switch_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit: picoMIPS instruction decode with a small stall FSM for
// multi-cycle multiply and switch waits. Decode is zero-latency; only the
// FSM state, the multiply counter and the switch synchroniser are registered.
//   clk, reset  : system clock, synchronous active-high reset
//   demoSwitch  : asynchronous board switch
//   cu (slave)  : opCode/aluFlags in; aluFunc, aluImmediate, immSwitches,
//                 pcInc, pcLoad, writeReg, stall out
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   RUN      | normal single-cycle decode; a MUL start enters MUL_WAIT
//   MUL_WAIT | multiply in progress; cnt counts remaining stall cycles
// ---------------------------------------------------------------------------
module control_unit
    import cpuConfig::*;
#(
    parameter int MUL_CYCLES  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          demoSwitch,
    control_unit_if.slave cu
);

    localparam int CW = $clog2(MUL_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_INIT = (MUL_CYCLES > 1) ? CW'(MUL_CYCLES - 2) : '0;

    ctrlState_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic sw_sync;
    logic sw_rise;

    aluFunc_t alu_func;
    logic     alu_imm;
    logic     imm_sw;
    logic     pc_inc;
    logic     pc_load;
    logic     write_reg;
    logic     stall_o;

    logic unused_flags;
    assign unused_flags = ^cu.aluFlags[FLAG_W-1:1];

    switch_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_switch_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (demoSwitch),
        .level    (sw_sync),
        .rise     (sw_rise)
    );

    always_comb begin
        alu_func  = ALU_A;
        alu_imm   = 1'b0;
        imm_sw    = 1'b0;
        pc_inc    = 1'b1;
        pc_load   = 1'b0;
        write_reg = 1'b1;
        stall_o   = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;

        if (state_q == MUL_WAIT) begin
            // The opcode is frozen while the PC is held, so the multiply
            // outputs do not depend on it here.
            alu_func = ALU_MUL;
            if (cnt_q != '0) begin
                stall_o   = 1'b1;
                pc_inc    = 1'b0;
                write_reg = 1'b0;
                cnt_d     = cnt_q - CW'(1);
            end else begin
                state_d = RUN;
            end
        end else begin
            case (cu.opCode)
                LDI: begin
                    alu_func = ALU_B;
                    alu_imm  = 1'b1;
                end
                LDS: begin
                    alu_func = ALU_B;
                    alu_imm  = 1'b1;
                    imm_sw   = 1'b1;
                end
                ADD: begin
                    alu_func = ALU_ADD;
                end
                ADDI: begin
                    alu_func = ALU_ADD;
                    alu_imm  = 1'b1;
                end
                MUL: begin
                    alu_func = ALU_MUL;
                    if (MUL_CYCLES > 1) begin
                        stall_o   = 1'b1;
                        pc_inc    = 1'b0;
                        write_reg = 1'b0;
                        state_d   = MUL_WAIT;
                        cnt_d     = CNT_INIT;
                    end
                end
                WAIT0: begin
                    write_reg = 1'b0;
                    pc_inc    = ~sw_sync;
                    stall_o   = sw_sync;
                end
                WAIT1: begin
                    write_reg = 1'b0;
                    pc_inc    = sw_sync;
                    stall_o   = ~sw_sync;
                end
                WAITE: begin
                    // Only a rise seen while sitting here releases the wait.
                    write_reg = 1'b0;
                    pc_inc    = sw_rise;
                    stall_o   = ~sw_rise;
                end
                BEQ: begin
                    write_reg = 1'b0;
                    pc_load   = cu.aluFlags[FLAG_Z];
                    pc_inc    = ~cu.aluFlags[FLAG_Z];
                end
                BNE: begin
                    write_reg = 1'b0;
                    pc_load   = ~cu.aluFlags[FLAG_Z];
                    pc_inc    = cu.aluFlags[FLAG_Z];
                end
                default: begin
                end
            endcase
        end

        if (reset) begin
            alu_func  = ALU_A;
            alu_imm   = 1'b0;
            imm_sw    = 1'b0;
            pc_inc    = 1'b0;
            pc_load   = 1'b0;
            write_reg = 1'b0;
            stall_o   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cu.aluFunc      = alu_func;
    assign cu.aluImmediate = alu_imm;
    assign cu.immSwitches  = imm_sw;
    assign cu.pcInc        = pc_inc;
    assign cu.pcLoad       = pc_load;
    assign cu.writeReg     = write_reg;
    assign cu.stall        = stall_o;

endmodule
